// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   state_e        : arbiter FSM states (IDLE/ISSUE/WAIT/RESP)
//   REQ_M0/REQ_M1  : requester ids (m0 = core load/store, m1 = debug/DMA)
//   RD_LAT_DEFAULT : default memory read latency in cycles
//   id2onehot      : requester id -> one-hot grant vector
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  localparam int unsigned RD_LAT_DEFAULT = 1;

  function automatic logic [1:0] id2onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of all request/response and memory-side signals of dmem_arbiter.
//   m0_* / m1_* : requester handshake (req_valid/req_ready), request fields
//                 (we/addr/wd) and response (rsp_valid/rd)
//   mem_*       : single shared data-memory port
//   m0_lock/m1_lock exist only when DMEM_ARB_LOCK_EN is defined.
// Modports:
//   slave  : the arbiter's view (takes requests, drives memory)
//   master : the requesters' and memory's view
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              m0_req_valid;
  logic              m0_req_ready;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wd;
  logic              m0_rsp_valid;
  logic [DATA_W-1:0] m0_rd;

  logic              m1_req_valid;
  logic              m1_req_ready;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wd;
  logic              m1_rsp_valid;
  logic [DATA_W-1:0] m1_rd;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_rd;

`ifdef DMEM_ARB_LOCK_EN
  logic              m0_lock;
  logic              m1_lock;
`endif

  modport slave (
`ifdef DMEM_ARB_LOCK_EN
    input  m0_lock, m1_lock,
`endif
    input  m0_req_valid, m0_we, m0_addr, m0_wd,
    input  m1_req_valid, m1_we, m1_addr, m1_wd,
    input  mem_rd,
    output m0_req_ready, m0_rsp_valid, m0_rd,
    output m1_req_ready, m1_rsp_valid, m1_rd,
    output mem_req, mem_we, mem_addr, mem_wd
  );

  modport master (
`ifdef DMEM_ARB_LOCK_EN
    output m0_lock, m1_lock,
`endif
    output m0_req_valid, m0_we, m0_addr, m0_wd,
    output m1_req_valid, m1_we, m1_addr, m1_wd,
    output mem_rd,
    input  m0_req_ready, m0_rsp_valid, m0_rd,
    input  m1_req_ready, m1_rsp_valid, m1_rd,
    input  mem_req, mem_we, mem_addr, mem_wd
  );

endinterface

// File: rtl/dmem_arbiter_rr2.sv
// arb_rr2: combinational two-way round-robin pick.
//   valid_i       : request valids {m1, m0}
//   rr_ptr_i      : requester preferred when both are eligible
//   lock_active_i : restrict eligibility to lock_owner_i
//   lock_owner_i  : id of the requester holding the lock
//   gnt_o         : one-hot grant {m1, m0}, zero when nobody is eligible
module arb_rr2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       rr_ptr_i,
  input  logic       lock_active_i,
  input  logic       lock_owner_i,
  output logic [1:0] gnt_o
);

  logic [1:0] elig;

  always_comb begin
    elig = valid_i;
    if (lock_active_i) begin
      elig = valid_i & id2onehot(lock_owner_i);
    end
    gnt_o = elig;
    if (&elig) begin
      gnt_o = id2onehot(rr_ptr_i);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core load/store
// path (m0) and a secondary master (m1). One request is accepted at a time
// in IDLE, issued as a one-cycle mem_req strobe, and answered RD_LAT cycles
// later (reads) or immediately after issue (writes) with a one-cycle
// rsp_valid pulse to the winner. Grants alternate round-robin.
// Ports:
//   clk : system clock
//   rst : synchronous, active-low reset
//   bus : dmem_arbiter_if.slave (m0_*, m1_*, mem_* signal groups)
// Parameters: ADDR_W, DATA_W, RD_LAT (1..15).
// Optional feature macro: DMEM_ARB_LOCK_EN adds m0_lock/m1_lock; a locked
// request pins the grant to its owner until the owner's next unlocked
// request completes.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = RD_LAT_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

  state_e            state_q;
  logic              rr_ptr_q;
  logic              win_q;
  logic              we_q;
  logic [3:0]        cnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wd_q;
  logic              rsp0_q;
  logic              rsp1_q;
  logic [DATA_W-1:0] rd0_q;
  logic [DATA_W-1:0] rd1_q;

  logic [1:0]        gnt;
  logic              idle_ok;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wd;
  logic              lock_active;
  logic              lock_owner;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q;
  logic lock_owner_q;
  logic lock_bit_q;
  logic sel_lock;

  assign sel_lock    = gnt[1] ? bus.m1_lock : bus.m0_lock;
  assign lock_active = lock_q;
  assign lock_owner  = lock_owner_q;
`else
  assign lock_active = 1'b0;
  assign lock_owner  = REQ_M0;
`endif

  arb_rr2 u_rr2 (
    .valid_i       ({bus.m1_req_valid, bus.m0_req_valid}),
    .rr_ptr_i      (rr_ptr_q),
    .lock_active_i (lock_active),
    .lock_owner_i  (lock_owner),
    .gnt_o         (gnt)
  );

  // Ready is gated by rst so nothing appears accepted while reset is held.
  assign idle_ok          = rst && (state_q == IDLE);
  assign bus.m0_req_ready = idle_ok && gnt[0];
  assign bus.m1_req_ready = idle_ok && gnt[1];

  assign sel_we   = gnt[1] ? bus.m1_we   : bus.m0_we;
  assign sel_addr = gnt[1] ? bus.m1_addr : bus.m0_addr;
  assign sel_wd   = gnt[1] ? bus.m1_wd   : bus.m0_wd;

  // The request fields are latched straight into the mem_* output registers:
  // they are only needed during ISSUE and are cleared on leaving it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= REQ_M0;
      win_q      <= REQ_M0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rd0_q      <= '0;
      rd1_q      <= '0;
`ifdef DMEM_ARB_LOCK_EN
      lock_q       <= 1'b0;
      lock_owner_q <= REQ_M0;
      lock_bit_q   <= 1'b0;
`endif
    end else begin
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            win_q      <= gnt[1];
            we_q       <= sel_we;
            mem_req_q  <= 1'b1;
            mem_we_q   <= sel_we;
            mem_addr_q <= sel_addr;
            mem_wd_q   <= sel_wd;
            state_q    <= ISSUE;
`ifdef DMEM_ARB_LOCK_EN
            lock_bit_q <= sel_lock;
            if (sel_lock) begin
              lock_q       <= 1'b1;
              lock_owner_q <= gnt[1];
            end
`endif
          end
        end
        ISSUE: begin
          if (!lock_active) begin
            rr_ptr_q <= ~win_q;
          end
          if (we_q) begin
            if (win_q == REQ_M1) begin
              rsp1_q <= 1'b1;
              rd1_q  <= '0;
            end else begin
              rsp0_q <= 1'b1;
              rd0_q  <= '0;
            end
            state_q <= RESP;
          end else begin
            cnt_q   <= LAT_LOAD;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            if (win_q == REQ_M1) begin
              rsp1_q <= 1'b1;
              rd1_q  <= bus.mem_rd;
            end else begin
              rsp0_q <= 1'b1;
              rd0_q  <= bus.mem_rd;
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
`ifdef DMEM_ARB_LOCK_EN
          if (lock_q && !lock_bit_q && (win_q == lock_owner_q)) begin
            lock_q <= 1'b0;
          end
`endif
        end
      endcase
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wd       = mem_wd_q;
  assign bus.m0_rsp_valid = rsp0_q;
  assign bus.m1_rsp_valid = rsp1_q;
  assign bus.m0_rd        = rd0_q;
  assign bus.m1_rd        = rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: dut_a uses RD_LAT=1, dut_b RD_LAT=4.
// Each has a small memory model that presents read data only in the single
// cycle RD_LAT cycles after mem_req (a poison value otherwise).
module tb_dmem_arbiter;

  localparam logic [31:0] POISON = 32'hBAD0_BAD0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  int          pa_cnt = 0;
  int          pb_cnt = 0;
  logic [31:0] pa_data = '0;
  logic [31:0] pb_data = '0;

  // Memory models, sampled on the falling edge; data is valid exactly in
  // cycle (mem_req cycle + RD_LAT).
  always @(negedge clk) begin
    if (bus_a.mem_req) begin
      if (bus_a.mem_we) mem_a[bus_a.mem_addr[9:2]] = bus_a.mem_wd;
      else begin
        pa_cnt  = 2;
        pa_data = mem_a[bus_a.mem_addr[9:2]];
      end
    end else if (pa_cnt != 0) pa_cnt--;
    bus_a.mem_rd = (pa_cnt == 1) ? pa_data : POISON;
  end

  always @(negedge clk) begin
    if (bus_b.mem_req) begin
      if (bus_b.mem_we) mem_b[bus_b.mem_addr[9:2]] = bus_b.mem_wd;
      else begin
        pb_cnt  = 5;
        pb_data = mem_b[bus_b.mem_addr[9:2]];
      end
    end else if (pb_cnt != 0) pb_cnt--;
    bus_b.mem_rd = (pb_cnt == 1) ? pb_data : POISON;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk(tag, {bus_a.m0_req_ready, bus_a.m1_req_ready, bus_a.m0_rsp_valid, bus_a.m1_rsp_valid,
              bus_a.mem_req, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wd}, '0);
    chk({tag, "_rd"}, {bus_a.m0_rd, bus_a.m1_rd}, '0);
  endtask

  task automatic chk_zero_b(input string tag);
    chk(tag, {bus_b.m0_req_ready, bus_b.m1_req_ready, bus_b.m0_rsp_valid, bus_b.m1_rsp_valid,
              bus_b.mem_req, bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wd}, '0);
    chk({tag, "_rd"}, {bus_b.m0_rd, bus_b.m1_rd}, '0);
  endtask

  task automatic drv_a(input logic id, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    if (id) begin
      bus_a.m1_req_valid = 1'b1; bus_a.m1_we = we; bus_a.m1_addr = addr; bus_a.m1_wd = wd;
    end else begin
      bus_a.m0_req_valid = 1'b1; bus_a.m0_we = we; bus_a.m0_addr = addr; bus_a.m0_wd = wd;
    end
  endtask

  task automatic drop_a(input logic id);
    if (id) begin
      bus_a.m1_req_valid = 1'b0; bus_a.m1_we = 1'b0; bus_a.m1_addr = '0; bus_a.m1_wd = '0;
    end else begin
      bus_a.m0_req_valid = 1'b0; bus_a.m0_we = 1'b0; bus_a.m0_addr = '0; bus_a.m0_wd = '0;
    end
  endtask

  task automatic drv_b(input logic id, input logic valid, input logic [31:0] addr);
    if (id) begin
      bus_b.m1_req_valid = valid; bus_b.m1_we = 1'b0; bus_b.m1_addr = addr; bus_b.m1_wd = '0;
    end else begin
      bus_b.m0_req_valid = valid; bus_b.m0_we = 1'b0; bus_b.m0_addr = addr; bus_b.m0_wd = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   g, cyc, last_cyc, i0, i1, r1cnt;
    logic last_we, pend0, pend1;

    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_b[4] = 32'hDEAD_BEEF;
    drop_a(1'b0); drop_a(1'b1);
    drv_b(1'b0, 1'b0, '0); drv_b(1'b1, 1'b0, '0);
`ifdef DMEM_ARB_LOCK_EN
    bus_a.m0_lock = 1'b0; bus_a.m1_lock = 1'b0;
    bus_b.m0_lock = 1'b0; bus_b.m1_lock = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero_a("rst_a");
    chk_zero_b("rst_b");
    rst = 1'b1;
    @(negedge clk);
    chk_zero_a("idle_a");

    // 1: m0 write 0x10 <- DEADBEEF
    drv_a(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    #1;
    chk("t1_ready0", bus_a.m0_req_ready, 1);
    chk("t1_ready1", bus_a.m1_req_ready, 0);
    @(negedge clk);
    chk("t1_mem", {bus_a.mem_req, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wd},
        {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF});
    chk("t1_rsp_early", bus_a.m0_rsp_valid, 0);
    drop_a(1'b0);
    @(negedge clk);
    chk("t1_rsp", bus_a.m0_rsp_valid, 1);
    chk("t1_m1_quiet", {bus_a.m1_req_ready, bus_a.m1_rsp_valid, bus_a.m1_rd}, '0);
    chk("t1_mem_off", bus_a.mem_req, 0);
    chk("t1_rd_zero", bus_a.m0_rd, 0);
    @(negedge clk);
    chk("t1_rsp_once", bus_a.m0_rsp_valid, 0);

    // 2a: m0 read 0x10, RD_LAT=1 -> response at T+3
    drv_a(1'b0, 1'b0, 32'h10, '0);
    #1;
    chk("t2_ready0", bus_a.m0_req_ready, 1);
    @(negedge clk);
    chk("t2_mem", {bus_a.mem_req, bus_a.mem_we, bus_a.mem_addr}, {1'b1, 1'b0, 32'h10});
    drop_a(1'b0);
    @(negedge clk);
    chk("t2_rsp_early", bus_a.m0_rsp_valid, 0);
    @(negedge clk);
    chk("t2_rsp", bus_a.m0_rsp_valid, 1);
    chk("t2_rd", bus_a.m0_rd, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_rsp_once", bus_a.m0_rsp_valid, 0);
    chk("t2_rd_hold", bus_a.m0_rd, 32'hDEAD_BEEF);

    // 2b: m0 read 0x10, RD_LAT=4 -> response at T+6
    drv_b(1'b0, 1'b1, 32'h10);
    #1;
    chk("t2b_ready0", bus_b.m0_req_ready, 1);
    @(negedge clk);
    chk("t2b_mem", bus_b.mem_req, 1);
    drv_b(1'b0, 1'b0, '0);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) chk("t2b_rsp_early", bus_b.m0_rsp_valid, 0);
      else begin
        chk("t2b_rsp", bus_b.m0_rsp_valid, 1);
        chk("t2b_rd", bus_b.m0_rd, 32'hDEAD_BEEF);
      end
    end
    @(negedge clk);
    chk("t2b_rsp_once", bus_b.m0_rsp_valid, 0);

    // 3: both valid after reset -> m0, then m1, then m0 again
    do_reset();
    drv_a(1'b0, 1'b1, 32'h20, 32'h1111_1111);
    drv_a(1'b1, 1'b1, 32'h24, 32'h2222_2222);
    #1;
    chk("t3_first", {bus_a.m1_req_ready, bus_a.m0_req_ready}, 2'b01);
    @(negedge clk);
    chk("t3_mem0", {bus_a.mem_addr, bus_a.mem_wd}, {32'h20, 32'h1111_1111});
    drop_a(1'b0);
    @(negedge clk);
    chk("t3_rsp0", bus_a.m0_rsp_valid, 1);
    chk("t3_m1_wait", bus_a.m1_req_ready, 0);
    @(negedge clk);
    chk("t3_second", bus_a.m1_req_ready, 1);
    @(negedge clk);
    chk("t3_mem1", {bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wd}, {1'b1, 32'h24, 32'h2222_2222});
    drop_a(1'b1);
    @(negedge clk);
    chk("t3_rsp1", {bus_a.m1_rsp_valid, bus_a.m0_rsp_valid, bus_a.m1_rd}, {2'b10, 32'h0});
    @(negedge clk);
    drv_a(1'b0, 1'b1, 32'h28, 32'h3333_3333);
    drv_a(1'b1, 1'b1, 32'h2C, 32'h4444_4444);
    #1;
    chk("t3_third", {bus_a.m1_req_ready, bus_a.m0_req_ready}, 2'b01);
    @(negedge clk);
    drop_a(1'b0);
    repeat (2) @(negedge clk);
    chk("t3_fourth", bus_a.m1_req_ready, 1);
    @(negedge clk);
    drop_a(1'b1);
    repeat (2) @(negedge clk);

    // 4: continuous contention, m0 writes / m1 reads back the same words
    do_reset();
    g = 0; cyc = 0; last_cyc = 0; i0 = 0; i1 = 0; r1cnt = 0;
    last_we = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
    drv_a(1'b0, 1'b1, 32'h100, 32'hA500_0000);
    drv_a(1'b1, 1'b0, 32'h100, '0);
    while (cyc < 300 && !(g >= 20 && r1cnt >= 10)) begin
      #1;
      if (bus_a.m0_req_ready || bus_a.m1_req_ready) begin
        chk("t4_onehot", bus_a.m0_req_ready & bus_a.m1_req_ready, 0);
        chk("t4_order", bus_a.m1_req_ready, g % 2);
        if (g > 0) chk("t4_gap", cyc - last_cyc, last_we ? 3 : 4);
        last_cyc = cyc;
        last_we  = bus_a.m0_req_ready;
        pend0    = bus_a.m0_req_ready;
        pend1    = bus_a.m1_req_ready;
        g++;
      end
      @(negedge clk);
      cyc++;
      if (bus_a.m1_rsp_valid) begin
        chk("t4_m1_rd", bus_a.m1_rd, 32'hA500_0000 + r1cnt);
        r1cnt++;
      end
      if (pend0) begin
        i0++;
        if (i0 < 10) drv_a(1'b0, 1'b1, 32'h100 + 4 * i0, 32'hA500_0000 + i0);
        else drop_a(1'b0);
        pend0 = 1'b0;
      end
      if (pend1) begin
        i1++;
        if (i1 < 10) drv_a(1'b1, 1'b0, 32'h100 + 4 * i1, '0);
        else drop_a(1'b1);
        pend1 = 1'b0;
      end
    end
    chk("t4_grants", g, 20);
    chk("t4_rsps", r1cnt, 10);
    repeat (2) @(negedge clk);

    // 5: reset during WAIT of an m1 read on dut_b; dut_a rr_ptr left at 1
    drv_a(1'b0, 1'b1, 32'h40, 32'h55);
    drv_b(1'b1, 1'b1, 32'h10);
    #1;
    chk("t5_ready1", bus_b.m1_req_ready, 1);
    @(negedge clk);
    chk("t5_issue", bus_b.mem_req, 1);
    drop_a(1'b0);
    drv_b(1'b1, 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero_b("t5_rst_b");
    chk_zero_a("t5_rst_a");
    rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("t5_no_rsp", bus_b.m1_rsp_valid, 0);
    end
    drv_a(1'b0, 1'b1, 32'h44, 32'h66);
    drv_a(1'b1, 1'b1, 32'h48, 32'h77);
    #1;
    chk("t5_rr_reset", {bus_a.m1_req_ready, bus_a.m0_req_ready}, 2'b01);
    @(negedge clk);
    drop_a(1'b0);
    drop_a(1'b1);
    drv_b(1'b1, 1'b1, 32'h10);
    #1;
    chk("t5_new_ready", bus_b.m1_req_ready, 1);
    @(negedge clk);
    chk("t5_new_issue", bus_b.mem_req, 1);
    drv_b(1'b1, 1'b0, '0);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (k < 6) chk("t5_new_early", bus_b.m1_rsp_valid, 0);
      else chk("t5_new_rsp", {bus_b.m1_rsp_valid, bus_b.m1_rd}, {1'b1, 32'hDEAD_BEEF});
    end
    repeat (2) @(negedge clk);

`ifdef DMEM_ARB_LOCK_EN
    // 6: m0 locks for 3 reads then an unlocked write; m1 valid throughout
    begin
      int gid [6];
      int gcyc [6];
      for (int k = 0; k < 6; k++) begin
        gid[k] = -1;
        gcyc[k] = 0;
      end
      do_reset();
      g = 0; cyc = 0; i0 = 0; pend0 = 1'b0; pend1 = 1'b0;
      drv_a(1'b0, 1'b0, 32'h10, '0);
      bus_a.m0_lock = 1'b1;
      drv_a(1'b1, 1'b1, 32'h80, 32'h99);
      while (cyc < 100 && g < 5) begin
        #1;
        if (bus_a.m0_req_ready || bus_a.m1_req_ready) begin
          gid[g]  = bus_a.m1_req_ready ? 1 : 0;
          gcyc[g] = cyc;
          pend0   = bus_a.m0_req_ready;
          pend1   = bus_a.m1_req_ready;
          g++;
        end
        @(negedge clk);
        cyc++;
        if (pend0) begin
          i0++;
          if (i0 == 3) begin
            drv_a(1'b0, 1'b1, 32'h84, 32'h77);
            bus_a.m0_lock = 1'b0;
          end else if (i0 >= 4) drop_a(1'b0);
          pend0 = 1'b0;
        end
        if (pend1) begin
          drop_a(1'b1);
          pend1 = 1'b0;
        end
      end
      chk("t6_grants", g, 5);
      for (int k = 0; k < 4; k++) chk("t6_m0_owner", gid[k], 0);
      chk("t6_m1_last", gid[4], 1);
      chk("t6_read_gap", gcyc[1] - gcyc[0], 4);
      chk("t6_m1_after_resp", gcyc[4] - gcyc[3], 3);
      repeat (4) @(negedge clk);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
